seq_div: RTL and testbench

- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational 4x4->8 multiplier (mul).
- Divides a DW-bit dividend by a VW-bit divisor and returns a DW-bit quotient and a VW-bit remainder.
- Resolves one quotient bit per clock.
- Used by the arithmetic unit with a start/busy/done handshake, so that dividend == quotient*divisor + remainder closes the loop with mul results.

---
 rtl/seq_div_if.sv | 25 ++
 rtl/seq_div.sv | 105 ++++++++++
 tb/tb_seq_div.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// Handshake and operand/result bundle between the arithmetic unit and seq_div.
// The requester drives start with operands; the divider returns status and results.
interface seq_div_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock, DW+1 cycles start-to-done
// (2 for a zero divisor). start is only honoured in IDLE; results hold until the next accepted start.
module seq_div #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic   clk,
  input  logic   rst,
  seq_div_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q;
  logic [VW-1:0] r_q;
  logic [DW-1:0] q_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] div_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  logic [VW:0]   t_d;
  logic          ge_d;
  logic [VW-1:0] r_d;
  logic [DW-1:0] q_d;

  // One restoring step: the partial remainder stays below the divisor, so VW bits hold it.
  always_comb begin
    t_d  = {r_q, q_q[DW-1]};
    ge_d = (t_d >= {1'b0, div_q});
    r_d  = ge_d ? VW'(t_d - {1'b0, div_q}) : VW'(t_d);
    q_d  = {q_q[DW-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              div_q   <= bus.divisor;
              r_q     <= '0;
              q_q     <= bus.dividend;
              cnt_q   <= CW'(DW - 1);
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else begin
              quot_q  <= '1;
              rem_q   <= bus.dividend[VW-1:0];
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        BUSY: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // Zero-divisor entry arrives with done still low: raise it for one cycle first.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed scenarios plus randomized operands against an arithmetic model.
module tb_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  seq_div_if #(.DW(8), .VW(4)) bus ();

  seq_div #(.DW(8), .VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one start, then watch until done (bounded). lat counts cycles after the start edge.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                        output int lat, output int bcnt,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output logic busy_at_done);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = dd; bus.divisor = dv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; bcnt = 0; q = 'x; r = 'x; z = 'x; busy_at_done = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) begin
        lat = k; q = bus.quotient; r = bus.remainder;
        z = bus.div_by_zero; busy_at_done = bus.busy;
        break;
      end
    end
  endtask

  // Compare one result against the arithmetic reference.
  task automatic check_op(input string name, input logic [7:0] dd, input logic [3:0] dv,
                          input int lat, input int bcnt, input logic [7:0] q,
                          input logic [3:0] r, input logic z, input logic bad);
    logic [7:0] eq; logic [3:0] er; logic ez; int elat; int ebc;
    if (dv == 0) begin
      eq = 8'hFF; er = dd[3:0]; ez = 1'b1; elat = 2; ebc = 0;
    end else begin
      eq = dd / dv; er = 4'(dd % dv); ez = 1'b0; elat = 9; ebc = 8;
    end
    ntests++;
    if (lat != elat) begin nfail++; $display("FAIL %s latency got %0d want %0d", name, lat, elat); end
    ntests++;
    if (bcnt != ebc) begin nfail++; $display("FAIL %s busy_cycles got %0d want %0d", name, bcnt, ebc); end
    ntests++;
    if (q !== eq) begin nfail++; $display("FAIL %s quotient got %0d want %0d", name, q, eq); end
    ntests++;
    if (r !== er) begin nfail++; $display("FAIL %s remainder got %0d want %0d", name, r, er); end
    ntests++;
    if (z !== ez) begin nfail++; $display("FAIL %s div_by_zero got %b want %b", name, z, ez); end
    ntests++;
    if (bad !== 1'b0) begin nfail++; $display("FAIL %s busy_at_done got %b want 0", name, bad); end
    if (dv != 0) begin
      ntests++;
      if ((16'(q) * 16'(dv) + 16'(r)) != 16'(dd)) begin
        nfail++; $display("FAIL %s mul_loop got %0d want %0d", name, q * dv + r, dd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ntests++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 15'd0) begin
      nfail++; $display("FAIL reset_state got b%b d%b z%b q%0d r%0d want all 0",
                        bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    rst = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    ntests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      nfail++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    run_op(8'd15, 4'd5, lat, bc, q, r, z, bad);
    check_op("div_15_5", 8'd15, 4'd5, lat, bc, q, r, z, bad);
    @(negedge clk);
    ntests++;
    if (bus.done !== 1'b0) begin nfail++; $display("FAIL done_one_cycle got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    run_op(8'd15, 4'd1, lat, bc, q, r, z, bad);
    check_op("b2b_15_1", 8'd15, 4'd1, lat, bc, q, r, z, bad);
    run_op(8'd255, 4'd15, lat, bc, q, r, z, bad);
    check_op("b2b_255_15", 8'd255, 4'd15, lat, bc, q, r, z, bad);
  endtask

  task automatic test_directed();
    int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    run_op(8'd200, 4'd7, lat, bc, q, r, z, bad);
    check_op("div_200_7", 8'd200, 4'd7, lat, bc, q, r, z, bad);
    run_op(8'd3, 4'd9, lat, bc, q, r, z, bad);
    check_op("div_3_9", 8'd3, 4'd9, lat, bc, q, r, z, bad);
    run_op(8'd0, 4'd6, lat, bc, q, r, z, bad);
    check_op("div_0_6", 8'd0, 4'd6, lat, bc, q, r, z, bad);
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    run_op(8'd100, 4'd0, lat, bc, q, r, z, bad);
    check_op("div_100_0", 8'd100, 4'd0, lat, bc, q, r, z, bad);
    repeat (4) @(negedge clk);
    bus.dividend = 8'd7; bus.divisor = 4'd3;
    repeat (2) @(negedge clk);
    ntests++;
    if (bus.quotient !== 8'hFF || bus.remainder !== 4'd4 || bus.div_by_zero !== 1'b1) begin
      nfail++; $display("FAIL hold_results got q%0d r%0d z%b want q255 r4 z1",
                        bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_start_busy();
    int ndone = 0; logic [7:0] q = '0; logic [3:0] r = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = (k == 3); bus.dividend = (k >= 3) ? 8'd15 : 8'd200;
      bus.divisor = (k >= 3) ? 4'd5 : 4'd7;
      if (bus.done === 1'b1) begin ndone++; q = bus.quotient; r = bus.remainder; end
    end
    bus.start = 1'b0;
    ntests++;
    if (ndone != 1) begin nfail++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
    ntests++;
    if (q !== 8'd28 || r !== 4'd4) begin
      nfail++; $display("FAIL busy_start_result got %0d r %0d want 28 r 4", q, r);
    end
  endtask

  task automatic test_reset_midop();
    int ndone = 0; int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    ntests++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== 14'd0) begin
      nfail++; $display("FAIL reset_midop got b%b d%b q%0d r%0d want all 0",
                        bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    ntests++;
    if (ndone != 0) begin nfail++; $display("FAIL reset_no_done got %0d active cycles want 0", ndone); end
    run_op(8'd15, 4'd5, lat, bc, q, r, z, bad);
    check_op("after_reset_15_5", 8'd15, 4'd5, lat, bc, q, r, z, bad);
  endtask

  task automatic test_random();
    int lat, bc; logic [7:0] q; logic [3:0] r; logic z, bad;
    logic [7:0] dd; logic [3:0] dv;
    for (int i = 0; i < 30; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_op(dd, dv, lat, bc, q, r, z, bad);
      check_op("random", dd, dv, lat, bc, q, r, z, bad);
      if (dv != 0) begin
        ntests++;
        if (r >= dv) begin nfail++; $display("FAIL rem_lt_div got %0d want < %0d", r, dv); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_directed();
    test_div_zero();
    test_start_busy();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
